// File: rtl/beep_scheduler.sv
// Buzzer arbiter: fail effect > jump effect > background music, with effect note sequencing and square-wave generation.
// Optional BEEP_FX_QUEUE_EN: one-deep pending jump request replayed when the running effect finishes.
module beep_scheduler #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int HP_SHIFT    = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       music_en,
    input  logic [2:0] music_note,
    input  logic       jump_req,
    input  logic       fail_req,
    output logic       beep,
    output logic [1:0] active_src,
    output logic       fx_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUSIC = 2'd1,
        S_JUMP  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

`ifdef BEEP_FX_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    function automatic logic [16:0] half_period(input logic [2:0] t);
        logic [16:0] hp;
        case (t)
            3'd1:    hp = 17'd95602;
            3'd2:    hp = 17'd85179;
            3'd3:    hp = 17'd75873;
            3'd4:    hp = 17'd71633;
            3'd5:    hp = 17'd63776;
            3'd6:    hp = 17'd56818;
            3'd7:    hp = 17'd50619;
            default: hp = 17'd0;
        endcase
        return hp >> HP_SHIFT;
    endfunction

    function automatic logic [2:0] fx_tone(input state_t s, input logic [1:0] idx);
        logic [2:0] t;
        if (s == S_JUMP) begin
            t = (idx == 2'd0) ? 3'd3 : 3'd5;
        end else begin
            case (idx)
                2'd0:    t = 3'd5;
                2'd1:    t = 3'd3;
                2'd2:    t = 3'd2;
                default: t = 3'd1;
            endcase
        end
        return t;
    endfunction

    function automatic logic [4:0] fx_ticks(input state_t s);
        return (s == S_JUMP) ? 5'd5 : 5'd20;
    endfunction

    state_t         state_q, state_n;
    logic [1:0]     note_q, note_n;
    logic [4:0]     tick_q, tick_n;
    logic [PW-1:0]  pre_q, pre_n;
    logic           pend_q, pend_n;
    logic           done_n;
    logic           clr_cnt;
    logic           last_note;
    logic           note_end;
    logic           pend_any;
    logic [2:0]     tone_q, tone_n;
    logic [16:0]    hp_q;
    logic           phase_restart;

    assign last_note = (state_q == S_JUMP) ? (note_q == 2'd1) : (note_q == 2'd3);
    assign note_end  = (pre_q == PRE_LAST) && (tick_q == 5'(fx_ticks(state_q) - 5'd1));
    assign pend_any  = pend_q || (QUEUE_EN && jump_req);

    // State and note-sequencing registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            note_q  <= 2'd0;
            tick_q  <= 5'd0;
            pre_q   <= '0;
            pend_q  <= 1'b0;
            fx_done <= 1'b0;
        end else begin
            state_q <= state_n;
            note_q  <= note_n;
            tick_q  <= tick_n;
            pre_q   <= pre_n;
            pend_q  <= pend_n;
            fx_done <= done_n;
        end
    end

    // Next-state, note advance and pending-request logic
    always_comb begin
        state_n = state_q;
        note_n  = note_q;
        tick_n  = tick_q;
        pre_n   = pre_q;
        pend_n  = pend_q;
        done_n  = 1'b0;
        clr_cnt = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_n  = '0;
            tick_n = tick_q + 5'd1;
        end else begin
            pre_n = pre_q + 1'b1;
        end
        case (state_q)
            S_IDLE, S_MUSIC: begin
                note_n  = 2'd0;
                clr_cnt = 1'b1;
                if (fail_req)                           state_n = S_FAIL;
                else if (jump_req)                      state_n = S_JUMP;
                else if (state_q == S_IDLE && music_en) state_n = S_MUSIC;
                else if (state_q == S_MUSIC && !music_en) state_n = S_IDLE;
            end
            S_JUMP, S_FAIL: begin
                if (state_q == S_JUMP && fail_req) begin
                    state_n = S_FAIL;
                    note_n  = 2'd0;
                    clr_cnt = 1'b1;
                end else if (state_q == S_JUMP && jump_req && !(QUEUE_EN && last_note)) begin
                    note_n  = 2'd0;
                    clr_cnt = 1'b1;
                end else begin
                    if (QUEUE_EN && jump_req) pend_n = 1'b1;
                    if (note_end) begin
                        clr_cnt = 1'b1;
                        if (last_note) begin
                            done_n  = 1'b1;
                            note_n  = 2'd0;
                            pend_n  = 1'b0;
                            state_n = pend_any ? S_JUMP : (music_en ? S_MUSIC : S_IDLE);
                        end else begin
                            note_n = note_q + 2'd1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (clr_cnt) begin
            tick_n = 5'd0;
            pre_n  = '0;
        end
    end

    // Outputs and the tone that applies from the next cycle on
    always_comb begin
        active_src = state_q;
        case (state_n)
            S_MUSIC:        tone_n = music_note;
            S_JUMP, S_FAIL: tone_n = fx_tone(state_n, note_n);
            default:        tone_n = 3'd0;
        endcase
        phase_restart = (state_n != state_q) || (note_n != note_q) ||
                        (tone_n != tone_q) || (clr_cnt && state_q inside {S_JUMP, S_FAIL});
    end

    // Square-wave generator; any tone context change restarts the phase low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tone_q <= 3'd0;
            hp_q   <= 17'd0;
            beep   <= 1'b0;
        end else begin
            tone_q <= tone_n;
            if (phase_restart || tone_q == 3'd0) begin
                hp_q <= 17'd0;
                beep <= 1'b0;
            end else if (hp_q == half_period(tone_q) - 17'd1) begin
                hp_q <= 17'd0;
                beep <= ~beep;
            end else begin
                hp_q <= hp_q + 17'd1;
            end
        end
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler: reset, jump, music preemption, fail-over-jump, rest and async reset.
// Expected half-periods are queued when stimulus is applied and popped when the wave is measured.
module tb_beep_scheduler;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       music_en = 1'b0;
    logic [2:0] music_note = 3'd0;
    logic       jump_req = 1'b0;
    logic       fail_req = 1'b0;
    logic       beep;
    logic [1:0] active_src;
    logic       fx_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fx_cnt = 0;
    logic [31:0] exp_q[$];

    beep_scheduler #(.TICK_CYCLES(100), .HP_SHIFT(10)) dut (
        .clk(clk), .rstn(rstn), .music_en(music_en), .music_note(music_note),
        .jump_req(jump_req), .fail_req(fail_req), .beep(beep),
        .active_src(active_src), .fx_done(fx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fx_done === 1'b1) fx_cnt <= fx_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %0d expected <empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Measures one full beep half-period (edge to edge), bounded
    task automatic measure_hp(input string tag, input int exp);
        int n;
        logic b;
        exp_q.push_back(exp);
        b = beep;
        n = 0;
        while (beep === b && n < 1000) begin @(negedge clk); n++; end
        b = beep;
        n = 0;
        while (beep === b && n < 1000) begin @(negedge clk); n++; end
        check_pop(tag, n);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_fx(output int at);
        int n;
        n = 0;
        at = -1;
        while (fx_done !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
        if (fx_done === 1'b1) at = cyc;
    endtask

    task automatic wait_beep_high();
        int n;
        n = 0;
        while (beep !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    endtask

    task automatic pulse_jump();
        @(negedge clk) jump_req = 1'b1;
        @(negedge clk) jump_req = 1'b0;
    endtask

    task automatic pulse_fail();
        @(negedge clk) fail_req = 1'b1;
        @(negedge clk) fail_req = 1'b0;
    endtask

    initial begin
        int entry, entry2, fentry, at, bad, snap;

        // Reset and idle
        repeat (5) @(negedge clk);
        check("rst_beep", beep, 0);
        check("rst_src", active_src, 0);
        check("rst_fx_done", fx_done, 0);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (beep !== 1'b0 || active_src !== 2'd0 || fx_done !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Single jump effect
        pulse_jump();
        entry = cyc;
        check("jump_src", active_src, 2);
        measure_hp("jump_hp0_a", 74);
        measure_hp("jump_hp0_b", 74);
        wait_until(entry + 505);
        measure_hp("jump_hp1", 62);
        wait_fx(at);
        check("jump_fx_time", at - entry, 1000);
        check("jump_end_src", active_src, 0);
        @(negedge clk);
        check("jump_fx_width", fx_done, 0);

        // Music with jump preemption and restart
        @(negedge clk) begin music_en = 1'b1; music_note = 3'd1; end
        @(negedge clk);
        check("music_src", active_src, 1);
        measure_hp("music_hp", 93);
        wait_beep_high();
        repeat (10) @(negedge clk);
        pulse_jump();
        entry = cyc;
        check("preempt_src", active_src, 2);
        check("preempt_phase", beep, 0);
        measure_hp("preempt_jump_hp", 74);
        wait_fx(at);
        check("preempt_fx_time", at - entry, 1000);
        check("preempt_back_src", active_src, 1);
        measure_hp("music_after_jump_hp", 93);
        pulse_jump();
        entry = cyc;
        wait_until(entry + 300);
        pulse_jump();
        entry2 = cyc;
        wait_fx(at);
        check("jump_restart_fx_time", at - entry2, 1000);

        // Rest note holds beep low while music owns the buzzer
        @(negedge clk) music_note = 3'd0;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (beep !== 1'b0) bad++;
        end
        check("rest_src", active_src, 1);
        check("rest_beep_low", bad, 0);
        @(negedge clk) music_note = 3'd1;
        measure_hp("music_resume_hp", 93);
        @(negedge clk) music_en = 1'b0;
        repeat (2) @(negedge clk);
        check("music_off_src", active_src, 0);

        // Fail preempts jump; a jump during fail is dropped (or queued)
        snap = fx_cnt;
        pulse_jump();
        entry = cyc;
        wait_until(entry + 200);
        pulse_fail();
        fentry = cyc;
        check("fail_src", active_src, 3);
        measure_hp("fail_hp0", 62);
        wait_until(fentry + 2005);
        measure_hp("fail_hp1", 74);
        wait_until(fentry + 3000);
        pulse_jump();
        check("fail_ignores_jump", active_src, 3);
        wait_until(fentry + 4005);
        measure_hp("fail_hp2", 83);
        wait_until(fentry + 6005);
        measure_hp("fail_hp3", 93);
        wait_fx(at);
        check("fail_fx_time", at - fentry, 8000);
`ifdef BEEP_FX_QUEUE_EN
        check("fail_end_src", active_src, 2);
`else
        check("fail_end_src", active_src, 0);
`endif
        @(negedge clk);
        check("fail_fx_width", fx_done, 0);
        check("fail_fx_count", fx_cnt - snap, 1);
`ifdef BEEP_FX_QUEUE_EN
        wait_fx(at);
        check("queued_jump_fx_time", at - (fentry + 8000), 1000);
        check("queued_jump_end_src", active_src, 0);
`endif

        // Asynchronous reset in the middle of a fail effect
        @(negedge clk) music_en = 1'b1;
        pulse_fail();
        fentry = cyc;
        check("fail2_src", active_src, 3);
        @(negedge clk) music_en = 1'b0;
        repeat (3) @(negedge clk);
        check("fail_holds_on_music_drop", active_src, 3);
        wait_until(fentry + 2500);
        wait_beep_high();
        check("pre_reset_beep", beep, 1);
        snap = fx_cnt;
        #2 rstn = 1'b0;
        #1;
        check("async_rst_beep", beep, 0);
        check("async_rst_src", active_src, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (9000) @(negedge clk);
        check("post_reset_no_fx", fx_cnt - snap, 0);
        check("post_reset_src", active_src, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
